// File: rtl/bridge_tx_ctrl.sv
// Result-side ping-pong tile store that streams each finished matrix downstream, one tile per beat.
// Define TRANSPOSE_OUT_EN to read tiles column-major (row advancing fastest) instead of row-major.
module bridge_tx_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int ROW_Y      = 4,
  parameter int COL_Y      = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       res_valid,
  input  logic [DATA_WIDTH-1:0]      res_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [DATA_WIDTH-1:0]      tx_data,
  output logic [$clog2(ROW_Y):0]     tx_row_idx,
  output logic [$clog2(COL_Y):0]     tx_col_idx,
  output logic                       tx_row_last,
  output logic                       tx_last,
  output logic                       mat_done,
  output logic                       overflow_err,
  output logic [1:0]                 bank_full
);

  localparam int DEPTH      = ROW_Y * COL_Y;
  localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW         = $clog2(ROW_Y) + 1;
  localparam int CW         = $clog2(COL_Y) + 1;

  localparam logic [0:0] T_IDLE = 1'b0;
  localparam logic [0:0] T_SEND = 1'b1;

  logic [DATA_WIDTH-1:0] mem_q [2][DEPTH];

  logic                  wr_bank_q, wr_bank_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [RW-1:0]         rd_row_q, rd_row_d;
  logic [CW-1:0]         rd_col_q, rd_col_d;
  logic [1:0]            bank_full_q, bank_full_d;
  logic                  overflow_err_q, overflow_err_d;
  logic                  mat_done_q, mat_done_d;
  logic [0:0]            state_q, state_d;

  logic                  wr_en;
  logic                  tx_hs;
  logic                  row_end;
  logic                  col_end;
  logic                  beat_last;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign rd_addr   = ADDR_WIDTH'(int'(rd_row_q) * COL_Y + int'(rd_col_q));
  assign row_end   = (rd_row_q == RW'(ROW_Y - 1));
  assign col_end   = (rd_col_q == CW'(COL_Y - 1));
  assign beat_last = (rd_addr == ADDR_WIDTH'(DEPTH - 1));
  assign tx_hs     = (state_q == T_SEND) && tx_ready;
  assign wr_en     = res_valid && !bank_full_q[wr_bank_q];

  always_comb begin
    wr_bank_d      = wr_bank_q;
    wr_addr_d      = wr_addr_q;
    rd_bank_d      = rd_bank_q;
    rd_row_d       = rd_row_q;
    rd_col_d       = rd_col_q;
    bank_full_d    = bank_full_q;
    overflow_err_d = overflow_err_q;
    mat_done_d     = 1'b0;
    state_d        = state_q;

    // Writes see the pre-edge full flags, so a same-edge release never admits a tile.
    if (res_valid && bank_full_q[wr_bank_q]) begin
      overflow_err_d = 1'b1;
    end
    if (wr_en) begin
      if (wr_addr_q == ADDR_WIDTH'(DEPTH - 1)) begin
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = !wr_bank_q;
        wr_addr_d              = '0;
      end else begin
        wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
      end
    end

    case (state_q)
      T_IDLE: begin
        if (bank_full_q[rd_bank_q]) begin
          state_d = T_SEND;
        end
      end
      default: begin
        if (tx_hs) begin
          if (beat_last) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = !rd_bank_q;
            rd_row_d               = '0;
            rd_col_d               = '0;
            mat_done_d             = 1'b1;
            state_d                = bank_full_q[!rd_bank_q] ? T_SEND : T_IDLE;
          end else begin
`ifdef TRANSPOSE_OUT_EN
            if (row_end) begin
              rd_row_d = '0;
              rd_col_d = rd_col_q + CW'(1);
            end else begin
              rd_row_d = rd_row_q + RW'(1);
            end
`else
            if (col_end) begin
              rd_col_d = '0;
              rd_row_d = rd_row_q + RW'(1);
            end else begin
              rd_col_d = rd_col_q + CW'(1);
            end
`endif
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q      <= 1'b0;
      wr_addr_q      <= '0;
      rd_bank_q      <= 1'b0;
      rd_row_q       <= '0;
      rd_col_q       <= '0;
      bank_full_q    <= 2'b00;
      overflow_err_q <= 1'b0;
      mat_done_q     <= 1'b0;
      state_q        <= T_IDLE;
    end else begin
      wr_bank_q      <= wr_bank_d;
      wr_addr_q      <= wr_addr_d;
      rd_bank_q      <= rd_bank_d;
      rd_row_q       <= rd_row_d;
      rd_col_q       <= rd_col_d;
      bank_full_q    <= bank_full_d;
      overflow_err_q <= overflow_err_d;
      mat_done_q     <= mat_done_d;
      state_q        <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_bank_q][wr_addr_q] <= res_data;
    end
  end

  assign tx_valid     = (state_q == T_SEND);
  assign tx_data      = mem_q[rd_bank_q][rd_addr];
  assign tx_row_idx   = rd_row_q;
  assign tx_col_idx   = rd_col_q;
`ifdef TRANSPOSE_OUT_EN
  assign tx_row_last  = tx_valid && row_end;
`else
  assign tx_row_last  = tx_valid && col_end;
`endif
  assign tx_last      = tx_valid && beat_last;
  assign mat_done     = mat_done_q;
  assign overflow_err = overflow_err_q;
  assign bank_full    = bank_full_q;

endmodule

// File: tb/tb_bridge_tx_ctrl.sv
// Scoreboard bench for bridge_tx_ctrl: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_bridge_tx_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid;
  logic [63:0] res_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [63:0] tx_data;
  logic [2:0]  tx_row_idx;
  logic [1:0]  tx_col_idx;
  logic        tx_row_last;
  logic        tx_last;
  logic        mat_done;
  logic        overflow_err;
  logic [1:0]  bank_full;

  bridge_tx_ctrl #(.DATA_WIDTH(64), .ROW_Y(4), .COL_Y(2)) dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_data(res_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_row_idx(tx_row_idx), .tx_col_idx(tx_col_idx),
    .tx_row_last(tx_row_last), .tx_last(tx_last), .mat_done(mat_done),
    .overflow_err(overflow_err), .bank_full(bank_full)
  );

  always #5 clk = ~clk;

  // Hand-derived beat order for a 4x2 tile matrix.
`ifdef TRANSPOSE_OUT_EN
  localparam int ORD [8] = '{0, 2, 4, 6, 1, 3, 5, 7};
  localparam int RI  [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  localparam int CI  [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
  localparam int RL  [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
`else
  localparam int ORD [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
  localparam int RI  [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
  localparam int CI  [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
  localparam int RL  [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif

  typedef struct packed {
    logic [63:0] data;
    logic [2:0]  ri;
    logic [1:0]  ci;
    logic        rl;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   md_cnt = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  task automatic push_matrix(input int base);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.data = 64'(base + ORD[k]);
      e.ri   = 3'(RI[k]);
      e.ci   = 2'(CI[k]);
      e.rl   = (RL[k] != 0);
      e.last = (k == 7);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: sample at negedge, away from the active edge.
  initial begin
    exp_t        e;
    logic        hold_pend = 1'b0;
    logic [63:0] hold_data;
    logic [2:0]  hold_ri;
    logic [1:0]  hold_ci;
    logic [1:0]  hold_fl;
    forever begin
      @(negedge clk);
      if (mat_done) md_cnt++;
      if (hold_pend) begin
        chk("hold_valid", 64'(tx_valid), 64'd1);
        chk("hold_data", tx_data, hold_data);
        chk("hold_row_idx", 64'(tx_row_idx), 64'(hold_ri));
        chk("hold_col_idx", 64'(tx_col_idx), 64'(hold_ci));
        chk("hold_flags", 64'({tx_row_last, tx_last}), 64'(hold_fl));
      end
      hold_pend = tx_valid && !tx_ready && !rst;
      hold_data = tx_data;
      hold_ri   = tx_row_idx;
      hold_ci   = tx_col_idx;
      hold_fl   = {tx_row_last, tx_last};
      if (tx_valid && tx_ready && !rst) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got data %0h, required no beat", tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", tx_data, e.data);
          chk("beat_row_idx", 64'(tx_row_idx), 64'(e.ri));
          chk("beat_col_idx", 64'(tx_col_idx), 64'(e.ci));
          chk("beat_row_last", 64'(tx_row_last), 64'(e.rl));
          chk("beat_last", 64'(tx_last), 64'(e.last));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic write_tile(input int d);
    res_valid = 1'b1;
    res_data  = 64'(d);
    @(posedge clk);
    #1;
    res_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_tx_last", 64'(tx_last), 64'd0);
    chk("rst_tx_row_last", 64'(tx_row_last), 64'd0);
    chk("rst_idx", 64'({tx_row_idx, tx_col_idx}), 64'd0);
    chk("rst_bank_full", 64'(bank_full), 64'd0);
    chk("rst_overflow", 64'(overflow_err), 64'd0);
    chk("rst_mat_done", 64'(mat_done), 64'd0);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget, output int n);
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s: got %0d beats outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int n;
    int md_base;
    rst       = 1'b1;
    res_valid = 1'b0;
    res_data  = '0;
    tx_ready  = 1'b0;

    // Fill one bank and stream it out.
    tx_ready = 1'b1;
    do_reset();
    md_base = md_cnt;
    push_matrix(0);
    for (int i = 0; i < 8; i++) write_tile(i);
    chk("f_valid_at_E", 64'(tx_valid), 64'd0);
    chk("f_bank_full", 64'(bank_full), 64'b01);
    @(posedge clk);
    #1;
    chk("f_valid_at_E1", 64'(tx_valid), 64'd1);
    wait_drain("f_drain", 40, n);
    repeat (3) begin @(posedge clk); #1; end
    chk("f_mat_done_cnt", 64'(md_cnt - md_base), 64'd1);
    chk("f_overflow", 64'(overflow_err), 64'd0);
    chk("f_bank_empty", 64'(bank_full), 64'd0);
    chk("f_idle", 64'(tx_valid), 64'd0);

    // Backpressure: ready alternates starting at 0.
    tx_ready = 1'b0;
    do_reset();
    md_base = md_cnt;
    push_matrix(0);
    for (int i = 0; i < 8; i++) write_tile(i);
    @(posedge clk);
    #1;
    chk("b_valid", 64'(tx_valid), 64'd1);
    for (int i = 0; i < 16; i++) begin
      tx_ready = i[0];
      @(posedge clk);
      #1;
    end
    chk("b_all_accepted", 64'(exp_q.size()), 64'd0);
    tx_ready = 1'b0;
    wait_drain("b_drain", 4, n);
    repeat (3) begin @(posedge clk); #1; end
    chk("b_mat_done_cnt", 64'(md_cnt - md_base), 64'd1);
    chk("b_overflow", 64'(overflow_err), 64'd0);

    // Overflow with both banks full, then back-to-back drain.
    tx_ready = 1'b0;
    do_reset();
    md_base = md_cnt;
    push_matrix(0);
    push_matrix(8);
    for (int i = 0; i < 16; i++) write_tile(i);
    chk("o_no_overflow_yet", 64'(overflow_err), 64'd0);
    write_tile(16);
    chk("o_bank_full", 64'(bank_full), 64'b11);
    chk("o_overflow", 64'(overflow_err), 64'd1);
    tx_ready = 1'b1;
    wait_drain("o_drain", 60, n);
    chk("o_drain_cycles", 64'(n), 64'd16);
    repeat (3) begin @(posedge clk); #1; end
    chk("o_mat_done_cnt", 64'(md_cnt - md_base), 64'd2);
    chk("o_overflow_sticky", 64'(overflow_err), 64'd1);
    chk("o_bank_empty", 64'(bank_full), 64'd0);

    // Simultaneous write and release of bank0.
    tx_ready = 1'b0;
    do_reset();
    md_base = md_cnt;
    push_matrix(0);
    push_matrix(8);
    push_matrix(100);
    for (int i = 0; i < 16; i++) write_tile(i);
    chk("s_overflow_pre", 64'(overflow_err), 64'd0);
    tx_ready = 1'b1;
    repeat (7) begin @(posedge clk); #1; end
    chk("s_beat7_last", 64'(tx_last), 64'd1);
    write_tile(99);
    chk("s_overflow", 64'(overflow_err), 64'd1);
    for (int i = 100; i < 108; i++) write_tile(i);
    wait_drain("s_drain", 60, n);
    repeat (3) begin @(posedge clk); #1; end
    chk("s_mat_done_cnt", 64'(md_cnt - md_base), 64'd3);

    // Reset mid-fill discards partial data.
    tx_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) write_tile(i);
    do_reset();
    md_base = md_cnt;
    push_matrix(10);
    for (int i = 10; i < 17; i++) begin
      write_tile(i);
      chk("r_valid_before_full", 64'(tx_valid), 64'd0);
    end
    write_tile(17);
    chk("r_valid_at_E", 64'(tx_valid), 64'd0);
    chk("r_bank_full", 64'(bank_full), 64'b01);
    @(posedge clk);
    #1;
    chk("r_valid_at_E1", 64'(tx_valid), 64'd1);
    wait_drain("r_drain", 40, n);
    repeat (3) begin @(posedge clk); #1; end
    chk("r_mat_done_cnt", 64'(md_cnt - md_base), 64'd1);
    chk("r_overflow", 64'(overflow_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bridge_tx_ctrl.md
Name: bridge_tx_ctrl

Overview:
- Output-side counterpart of the bridge buffer controller.
- Captures result blocks from the systolic wrapper; each block is one BLOCK_SIZE x BLOCK_SIZE tile, arriving as one res_valid pulse per accumulated tile in row-major tile order.
- Stores tiles in a two-bank ping-pong store and transmits each completed result matrix downstream over a valid/ready stream, one tile per beat.
- Feeds the next stage's bridge buffer, for example Q*K^T -> softmax, or the V matmul.

Parameters:
- DATA_WIDTH, 64, width of one result tile (BLOCK_SIZE*BLOCK_SIZE elements).
- ROW_Y, 4, tile rows in the result matrix.
- COL_Y, 2, tile columns in the result matrix.
- DEPTH (localparam), ROW_Y*COL_Y, tiles per bank.
- ADDR_WIDTH (localparam), max(1,$clog2(DEPTH)), bank address width.

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous reset, active-high
- res_valid  in  1  one-cycle strobe; res_data carries one tile
- res_data  in  DATA_WIDTH  result tile
- tx_valid  out  1  tile available on tx_data
- tx_ready  in  1  downstream accepts the beat when tx_valid && tx_ready
- tx_data  out  DATA_WIDTH  tile being transmitted
- tx_row_idx  out  $clog2(ROW_Y)+1  tile row of the current beat
- tx_col_idx  out  $clog2(COL_Y)+1  tile column of the current beat
- tx_row_last  out  1  current beat is the last tile of its row (last of its column when transposed)
- tx_last  out  1  current beat is the last tile of the matrix
- mat_done  out  1  one-cycle pulse after the final beat of a matrix is accepted
- overflow_err  out  1  sticky; a tile was dropped
- bank_full  out  2  per-bank full flags, for debug and status

Behaviour:
- Reset (rst=1 at a clock edge) clears:
  - wr_bank, wr_addr, rd_bank, rd_addr, bank_full, overflow_err, mat_done
  - the FSM, which returns to T_IDLE
  - store contents are don't-care
- Outputs while rst is applied, or right after it: tx_valid=0, tx_last=0, tx_row_last=0, tx_row_idx=0, tx_col_idx=0, tx_data don't-care.
- Reset mid-operation discards all stored and partially sent tiles. The next tile lands in bank0 at address 0.
- Write side (no backpressure; upstream cannot stall):
  - If res_valid and !bank_full[wr_bank]: write mem[wr_bank][wr_addr] and increment wr_addr.
  - When wr_addr==DEPTH-1 and a write occurs: set bank_full[wr_bank], toggle wr_bank, set wr_addr=0.
  - If res_valid and bank_full[wr_bank]: the tile is dropped, overflow_err<=1 (sticky until rst), and wr_addr is unchanged.
- Read FSM has two states:
  - T_IDLE: tx_valid=0. Moves to T_SEND at the edge where bank_full[rd_bank]==1.
  - T_SEND: tx_valid=1 and tx_data=mem[rd_bank][rd_addr], read combinationally. On handshake, rd_addr advances through the sequence below.
- Handshake of the last beat (tx_last):
  - Clear bank_full[rd_bank], toggle rd_bank, set rd_addr=0, and pulse mat_done on the next cycle.
  - Next state is T_SEND if the other bank is full, giving back-to-back matrices with no bubble; otherwise T_IDLE.
- Default read order is row-major: address = row*COL_Y + col, with col advancing fastest.
- Indices and flags:
  - tx_row_idx and tx_col_idx track the current beat.
  - tx_row_last = (col==COL_Y-1).
  - tx_last = (address==DEPTH-1).
- Latency: the final tile is sampled at edge E, bank_full is set after E, the FSM enters T_SEND at E+1, and tx_valid is high from E+1.
- Throughput: 1 tile/cycle while tx_ready=1.
- Stream rules:
  - tx_data, indices and flags stay stable while tx_valid && !tx_ready.
  - tx_valid never drops without a handshake.
- Simultaneous write and release: when the final-beat handshake and a res_valid targeting the same (full) bank fall on the same edge, the write sees the bank as full. The tile is dropped and overflow_err is set. The clear takes effect only after the edge.
- A write into the other bank on the same edge proceeds normally.

Optional Feature:
- Macro TRANSPOSE_OUT_EN.
- When defined, the read order is column-major: address = row*COL_Y + col, with row advancing fastest.
  - tx_row_last = (row==ROW_Y-1), marking the last tile of a column.
  - tx_last is still the final beat (row=ROW_Y-1, col=COL_Y-1).
  - This lets the block feed K^T directly as a north input.
- When not defined, the order is row-major as above. Write order is unaffected in both cases.

Test Plan:
- Fill one bank: rst, then 8 consecutive res_valid with data 0..7, tx_ready=1. Expect tx_valid high from the edge after the 8th write, then tx_data 0..7 on 8 consecutive cycles. Expect tx_row_last on 1,3,5,7, tx_last on 7, a single mat_done pulse, and overflow_err=0.
- Backpressure: same input, with tx_ready alternating 1/0 starting at 0. Expect tx_data held stable through each !ready cycle, 8 beats accepted over 16 cycles, order 0..7, no loss.
- Overflow: 17 res_valid with data 0..16 and tx_ready=0. Expect bank_full=2'b11, tile 16 dropped, overflow_err=1. Then tx_ready=1: expect 0..15 out back-to-back with no idle cycle between matrices, two mat_done pulses, and overflow_err still 1.
- Simultaneous write/release:
  - Both banks full with data 0..15, tx_ready=1.
  - Drive res_valid with data 99 on the handshake cycle of beat 7: expect it dropped, overflow_err=1.
  - Drive res_valid with data 100 on the next cycle: expect it written to bank0 address 0, and it is the first tile of the third matrix.
- Reset mid-operation: 5 writes (0..4), bank not yet full. Then assert rst for 1 cycle. Then 8 writes (10..17): expect output 10..17, with tx_valid=0 until the 8th write completes.
- With TRANSPOSE_OUT_EN defined, ROW_Y=4, COL_Y=2, data 0..7: expect output order 0,2,4,6,1,3,5,7, tx_row_last on 6 and 7, tx_last on 7.
